// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the NeoPixel frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    // One pixel is a GRB word, MSB shifted first.
    localparam int PIX_BITS = 24;

    // WS2812 timing at a 100 MHz ACLK.
    localparam int T0H_DEF    = 40;
    localparam int T1H_DEF    = 80;
    localparam int TBIT_DEF   = 125;
    localparam int TLATCH_DEF = 5000;

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// Command, pixel-buffer and LED-line signals of the frame sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; pixel data returns a fixed one cycle after the read strobe.
interface neopixel_frame_sequencer_if
    import neopixel_pkg::*;
#(
    parameter int PIXEL_CNT_W = 8
);
    logic                   start;
    logic                   stop;
    logic [PIXEL_CNT_W-1:0] num_pixels;
    logic                   pix_rd;
    logic [PIXEL_CNT_W-1:0] pix_addr;
    logic [PIX_BITS-1:0]    pix_data;
    logic                   dout;
    logic                   busy;
    logic                   done;

    // Host side: register block, pixel buffer and LED pin.
    modport master (
        output start, stop, num_pixels, pix_data,
        input  pix_rd, pix_addr, dout, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, stop, num_pixels, pix_data,
        output pix_rd, pix_addr, dout, busy, done
    );
endinterface

// File: rtl/neopixel_bit_encoder.sv
// Turns one load pulse + bit value into a TBIT-cycle WS2812 symbol (high T0H or T1H).
// Latency: dout rises the cycle after load; bit_done is high in the last cycle of the symbol.
// Backpressure: none; a load during bit_done chains the next symbol with no gap.
module neopixel_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic i_load,
    input  logic i_bit,
    output logic o_dout,
    output logic o_bit_done
);
    logic [15:0] r_cnt;
    logic [15:0] r_hi;
    logic        r_dout;
    logic        r_active;

    // Bit timer: r_cnt numbers the cycles of the symbol 1..TBIT; the line drops after r_hi cycles.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt    <= 16'd0;
            r_hi     <= 16'd0;
            r_dout   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_cnt    <= 16'd1;
            r_hi     <= i_bit ? 16'(T1H) : 16'(T0H);
            r_dout   <= 1'b1;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == r_hi) begin
                r_dout <= 1'b0;
            end
            if (r_cnt == 16'(TBIT)) begin
                r_active <= 1'b0;
                r_cnt    <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_bit_done = r_active && (r_cnt == 16'(TBIT));

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Fetches num_pixels GRB words, serializes them as WS2812 symbols, then latches and pulses done.
// Latency: pix_rd 1 cycle after start, first dout rise 3 cycles after start; pixel = 24*TBIT+2 cycles.
// Backpressure: none; start while busy is ignored, stop ends the frame at the next pixel boundary.
// Optional feature: define NEOPIXEL_REPEAT_EN to add repeat_en (frames restart after each latch).
module neopixel_frame_sequencer
    import neopixel_pkg::*;
#(
    parameter int PIXEL_CNT_W = 8,
    parameter int T0H         = T0H_DEF,
    parameter int T1H         = T1H_DEF,
    parameter int TBIT        = TBIT_DEF,
    parameter int TLATCH      = TLATCH_DEF
) (
    input  logic ACLK,
    input  logic ARESETN,
`ifdef NEOPIXEL_REPEAT_EN
    input  logic repeat_en,
`endif
    neopixel_frame_sequencer_if.slave bus
);
    localparam logic [PIXEL_CNT_W-1:0] CNT_ONE = PIXEL_CNT_W'(1);

    state_t                 r_state;
    logic [PIXEL_CNT_W-1:0] r_cnt;
    logic [PIXEL_CNT_W-1:0] r_addr;
    logic [PIX_BITS-1:0]    r_shift;
    logic [4:0]             r_bit_idx;
    logic                   r_stop_pend;
    logic                   r_pix_rd;
    logic                   r_busy;
    logic                   r_done;
    logic [15:0]            r_lat_left;

    logic w_load;
    logic w_bit;
    logic w_bit_done;
    logic w_dout;
    logic w_last_pix;

    // Launch a symbol when the pixel is captured and at every bit boundary except after bit 0.
    always_comb begin
        w_load = (r_state == ST_WAIT) ||
                 ((r_state == ST_SHIFT) && w_bit_done && (r_bit_idx != 5'd0));
        w_bit  = (r_state == ST_WAIT) ? bus.pix_data[PIX_BITS-1] : r_shift[PIX_BITS-2];
    end

    // A stop arriving on the boundary cycle itself still ends the frame there.
    assign w_last_pix = (r_cnt == CNT_ONE) || r_stop_pend || bus.stop;

    neopixel_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_enc (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .i_load     (w_load),
        .i_bit      (w_bit),
        .o_dout     (w_dout),
        .o_bit_done (w_bit_done)
    );

    // Frame FSM. LATCH lasts TLATCH+1 cycles: TLATCH low cycles plus the cycle carrying done.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_shift     <= '0;
            r_bit_idx   <= 5'd0;
            r_stop_pend <= 1'b0;
            r_pix_rd    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lat_left  <= 16'd0;
        end else begin
            r_pix_rd <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_cnt       <= bus.num_pixels;
                        r_addr      <= '0;
                        r_busy      <= 1'b1;
                        r_stop_pend <= 1'b0;
                        if (bus.num_pixels != '0) begin
                            r_state  <= ST_FETCH;
                            r_pix_rd <= 1'b1;
                        end else begin
                            r_state    <= ST_LATCH;
                            r_lat_left <= 16'(TLATCH);
                        end
                    end
                end
                ST_FETCH: begin
                    if (bus.stop) r_stop_pend <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.stop) r_stop_pend <= 1'b1;
                    r_shift   <= bus.pix_data;
                    r_bit_idx <= 5'(PIX_BITS - 1);
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.stop) r_stop_pend <= 1'b1;
                    if (w_bit_done) begin
                        if (r_bit_idx != 5'd0) begin
                            r_bit_idx <= r_bit_idx - 5'd1;
                            r_shift   <= r_shift << 1;
                        end else begin
                            r_addr <= r_addr + CNT_ONE;
                            r_cnt  <= r_cnt - CNT_ONE;
                            if (w_last_pix) begin
                                r_state    <= ST_LATCH;
                                r_lat_left <= 16'(TLATCH);
                            end else begin
                                r_state  <= ST_FETCH;
                                r_pix_rd <= 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_lat_left != 16'd0) begin
                        r_lat_left <= r_lat_left - 16'd1;
                        r_done     <= (r_lat_left == 16'd1);
                    end else begin
                        r_stop_pend <= 1'b0;
`ifdef NEOPIXEL_REPEAT_EN
                        if (repeat_en && !r_stop_pend) begin
                            r_cnt  <= bus.num_pixels;
                            r_addr <= '0;
                            if (bus.num_pixels != '0) begin
                                r_state  <= ST_FETCH;
                                r_pix_rd <= 1'b1;
                            end else begin
                                r_state    <= ST_LATCH;
                                r_lat_left <= 16'(TLATCH);
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_rd   = r_pix_rd;
    assign bus.pix_addr = r_addr;
    assign bus.dout     = w_dout;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Scoreboard bench for neopixel_frame_sequencer: expected reads, symbols and done pulses are
// queued with their absolute cycle numbers; a negedge monitor decodes the DUT and compares.
// With NEOPIXEL_REPEAT_EN defined the repeat-mode sequence is exercised as well.
module tb_neopixel_frame_sequencer;

    localparam int W      = 8;
    localparam int T0H    = 40;
    localparam int T1H    = 80;
    localparam int TBIT   = 125;
    localparam int TLATCH = 5000;
    localparam int PIXP   = 24 * TBIT + 2;

    localparam int EV_READ = 0;
    localparam int EV_BIT  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic ACLK;
    logic ARESETN;
`ifdef NEOPIXEL_REPEAT_EN
    logic repeat_en;
`endif

    neopixel_frame_sequencer_if #(.PIXEL_CNT_W(W)) bus ();

    neopixel_frame_sequencer #(
        .PIXEL_CNT_W (W),
        .T0H         (T0H),
        .T1H         (T1H),
        .TBIT        (TBIT),
        .TLATCH      (TLATCH)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
`ifdef NEOPIXEL_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .bus       (bus)
    );

    logic [23:0] mem [256];
    ev_t         exp_q [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        prev_dout = 1'b0;
    int          rise_cyc = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Pixel buffer: data is presented the cycle after the read strobe.
    always @(posedge ACLK) begin
        if (bus.pix_rd) bus.pix_data <= mem[bus.pix_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind, input int c, input int v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: kind=%0d cyc=%0d val=%0d, nothing expected", kind, c, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != c || e.val != v) begin
                n_errors++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%0d, expected kind=%0d cyc=%0d val=%0d",
                         kind, c, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: decode pulse widths on dout, read strobes and done pulses.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_dout = 1'b0;
        end else begin
            if (bus.dout && !prev_dout) rise_cyc = cyc;
            if (!bus.dout && prev_dout) check_ev(EV_BIT, rise_cyc, cyc - rise_cyc);
            if (bus.pix_rd) check_ev(EV_READ, cyc, int'(bus.pix_addr));
            if (bus.done) check_ev(EV_DONE, cyc, 0);
            prev_dout = bus.dout;
        end
    end

    // Reference model: a frame whose start is high in cycle s transmits n pixels
    // back to back, each 24*TBIT+2 cycles, followed by the latch and done.
    task automatic push_frame(input int s, input int n);
        logic [23:0] px;
        ev_t         e;
        for (int k = 0; k < n; k++) begin
            e.kind = EV_READ; e.cyc = s + 1 + k * PIXP; e.val = k % 256;
            exp_q.push_back(e);
            px = mem[k % 256];
            for (int b = 0; b < 24; b++) begin
                e.kind = EV_BIT;
                e.cyc  = s + 3 + k * PIXP + b * TBIT;
                e.val  = px[23 - b] ? T1H : T0H;
                exp_q.push_back(e);
            end
        end
        e.kind = EV_DONE; e.cyc = s + n * PIXP + TLATCH + 1; e.val = 0;
        exp_q.push_back(e);
    endtask

    // Pulse start for n pixels; n_eff is how many pixels the frame is expected to carry.
    task automatic kick(input int n, input int n_eff, output int s);
        @(posedge ACLK); #1;
        s = cyc;
        push_frame(s, n_eff);
        bus.num_pixels = W'(n);
        bus.start      = 1'b1;
        @(posedge ACLK); #1;
        bus.start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && !bus.busy) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s timeout: %0d events still pending, busy=%0d", name, exp_q.size(), bus.busy);
        exp_q.delete();
    endtask

    initial begin
        int s;
        int n;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.num_pixels = '0;
`ifdef NEOPIXEL_REPEAT_EN
        repeat_en      = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_dout", bus.dout, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_pix_rd", bus.pix_rd, 0);
        chk("reset_pix_addr", bus.pix_addr, 0);
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);

        // Single pixel with a known pattern.
        mem[0] = 24'hA50F00;
        kick(1, 1, s);
        chk("busy_after_start", bus.busy, 1);
        wait_idle("single_pixel", PIXP + TLATCH + 200);

        // Three pixels, with a start while busy that must be ignored.
        for (int i = 0; i < 3; i++) mem[i] = 24'($urandom);
        kick(3, 3, s);
        repeat (1000) @(posedge ACLK);
        #1;
        bus.num_pixels = W'(5);
        bus.start      = 1'b1;
        @(posedge ACLK); #1;
        bus.start      = 1'b0;
        wait_idle("three_pixel", 3 * PIXP + TLATCH + 200);

        // Simultaneous start and stop in IDLE is dropped.
        @(posedge ACLK); #1;
        bus.num_pixels = W'(2);
        bus.start      = 1'b1;
        bus.stop       = 1'b1;
        @(posedge ACLK); #1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        repeat (20) @(negedge ACLK);
        chk("start_stop_idle_busy", bus.busy, 0);

        // Zero pixels: latch only.
        kick(0, 0, s);
        wait_idle("zero_pixel", TLATCH + 200);

        // Stop during pixel 1 of a four-pixel frame: two pixels then latch.
        kick(4, 2, s);
        repeat (PIXP + 100) @(posedge ACLK);
        #1;
        bus.stop = 1'b1;
        @(posedge ACLK); #1;
        bus.stop = 1'b0;
        wait_idle("stop_frame", 2 * PIXP + TLATCH + 200);

        // Reset in the middle of pixel 0, then a clean frame from address 0.
        kick(2, 2, s);
        repeat (500) @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_dout", bus.dout, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_pix_addr", bus.pix_addr, 0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        mem[0] = 24'($urandom);
        kick(1, 1, s);
        wait_idle("post_reset", PIXP + TLATCH + 200);

        // Randomized frame lengths.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) mem[i] = 24'($urandom);
            n = int'($urandom_range(0, 2));
            kick(n, n, s);
            wait_idle("random_frame", n * PIXP + TLATCH + 200);
        end

`ifdef NEOPIXEL_REPEAT_EN
        // Repeat mode: second frame starts right after the first done; a stop in it
        // ends it at the pixel boundary and the sequencer returns to IDLE after the latch.
        repeat_en = 1'b1;
        @(posedge ACLK); #1;
        s = cyc;
        push_frame(s, 2);
        push_frame(s + 2 * PIXP + TLATCH + 1, 1);
        bus.num_pixels = W'(2);
        bus.start      = 1'b1;
        @(posedge ACLK); #1;
        bus.start      = 1'b0;
        repeat (2 * PIXP + TLATCH + 2) @(posedge ACLK);
        #1;
        chk("repeat_busy_held", bus.busy, 1);
        repeat (100) @(posedge ACLK);
        #1;
        bus.stop = 1'b1;
        @(posedge ACLK); #1;
        bus.stop = 1'b0;
        wait_idle("repeat_frame", 2 * PIXP + 2 * TLATCH + 400);
        repeat_en = 1'b0;
`endif

        repeat (10) @(negedge ACLK);
        chk("final_busy", bus.busy, 0);
        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
